// File: rtl/cgra_cfg_pkg.sv
// Shared types and defaults for the CGRA configuration sequencer.
package cgra_cfg_pkg;

  localparam int unsigned CFG_ADDR_W   = 32;
  localparam int unsigned CFG_DATA_W   = 32;
  localparam int unsigned CFG_CNT_W    = 32;
  // Address 0 is a no-op for the array's config decoder; an idle bus drives it.
  localparam int unsigned CFG_NOP_ADDR = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } seq_state_t;

  // States in which a start pulse launches a new sequence.
  function automatic logic accepts_start(input seq_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

  // States that count as busy; IDLE, DONE and ERROR are resting states.
  function automatic logic is_busy(input seq_state_t s);
    return !accepts_start(s);
  endfunction

endpackage

// File: rtl/cgra_cfg_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module cgra_cfg_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cgra_config_sequencer.sv
// Bring-up sequencer for the CGRA array: reset pulse, config stream, settle, timed run.
module cgra_config_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W        = CFG_ADDR_W,
  parameter int unsigned DATA_W        = CFG_DATA_W,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned CNT_W         = CFG_CNT_W
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              cgra_reset_out,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              busy,
  output logic              config_done,
  output logic              run_done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  // Terminal phase-counter values. SETTLE also holds the cycle that carries the
  // last accepted word, so it lasts SETTLE_CYCLES+1 cycles and leaves exactly
  // SETTLE_CYCLES zero-bus cycles before RUN.
  localparam int unsigned RST_LAST     = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
  localparam int unsigned SETTLE_LAST  = SETTLE_CYCLES;
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  seq_state_t        state;
  seq_state_t        state_nx;

  logic              accept;
  logic              start_go;
  logic              phase_clr;
  logic              idle_clr;
  logic              cycle_inc;
  logic [CNT_W-1:0]  phase_cnt;
  logic [CNT_W-1:0]  idle_cnt;
  logic [CNT_W-1:0]  run_last;

  logic              cfg_ready_nx;
  logic              cgra_reset_nx;
  logic              busy_nx;
  logic              config_done_nx;
  logic              run_done_nx;
  logic              error_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;

  // Handshake and start qualification; abort overrides both.
  assign accept   = cfg_valid & cfg_ready & ~abort;
  assign start_go = start & ~abort & accepts_start(state);

  // Counter controls: phase restarts on every state change, idle restarts on accept.
  assign phase_clr = (state_nx != state);
  assign idle_clr  = accept | (state != ST_LOAD);
  assign cycle_inc = (state == ST_RUN) & ~abort;

  cgra_cfg_sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (start_go),
    .inc      (accept),
    .count    (word_count)
  );

  cgra_cfg_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (start_go),
    .inc      (cycle_inc),
    .count    (cycle_count)
  );

  cgra_cfg_sat_counter #(.W(CNT_W)) u_phase_cnt (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (phase_clr),
    .inc      (1'b1),
    .count    (phase_cnt)
  );

  cgra_cfg_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (idle_clr),
    .inc      (1'b1),
    .count    (idle_cnt)
  );

  // Latch the final RUN count index on start; zero run cycles behaves like one.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      run_last <= '0;
    end else if (start_go) begin
      run_last <= (run_cycles == '0) ? '0 : run_cycles - CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; abort returns to IDLE ahead of everything else.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_go) state_nx = ST_RST;
        end
        ST_RST: begin
          if (phase_cnt == CNT_W'(RST_LAST)) state_nx = ST_LOAD;
        end
        ST_LOAD: begin
          if (accept && cfg_last) begin
            state_nx = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
          end else if (!accept && (idle_cnt == CNT_W'(TIMEOUT_LAST))) begin
            state_nx = ST_ERROR;
          end
        end
        ST_SETTLE: begin
          if (phase_cnt == CNT_W'(SETTLE_LAST)) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (cycle_count == run_last) state_nx = ST_DONE;
        end
        ST_DONE: begin
          if (start_go) state_nx = ST_RST;
        end
        ST_ERROR: begin
          if (start_go) state_nx = ST_RST;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so registered outputs track the state.
  always_comb begin
    cfg_ready_nx   = 1'b0;
    cgra_reset_nx  = 1'b0;
    busy_nx        = is_busy(state_nx);
    config_done_nx = 1'b0;
    run_done_nx    = 1'b0;
    error_nx       = 1'b0;
    addr_nx        = ADDR_W'(CFG_NOP_ADDR);
    data_nx        = '0;
    case (state_nx)
      ST_IDLE:  cgra_reset_nx  = 1'b1;
      ST_RST:   cgra_reset_nx  = 1'b1;
      ST_LOAD:  cfg_ready_nx   = 1'b1;
      ST_RUN:   config_done_nx = 1'b1;
      ST_DONE: begin
        config_done_nx = 1'b1;
        run_done_nx    = 1'b1;
      end
      ST_ERROR: begin
        cgra_reset_nx  = 1'b1;
        error_nx       = 1'b1;
      end
      default: begin
        cfg_ready_nx   = 1'b0;
      end
    endcase
    // An accepted word is presented for exactly the following cycle.
    if (accept) begin
      addr_nx = cfg_addr;
      data_nx = cfg_data;
    end
  end

  // Output registers; reset holds the array in reset with a quiet config bus.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cfg_ready       <= 1'b0;
      cgra_reset_out  <= 1'b1;
      config_addr_out <= '0;
      config_data_out <= '0;
      busy            <= 1'b0;
      config_done     <= 1'b0;
      run_done        <= 1'b0;
      error           <= 1'b0;
    end else begin
      cfg_ready       <= cfg_ready_nx;
      cgra_reset_out  <= cgra_reset_nx;
      config_addr_out <= addr_nx;
      config_data_out <= data_nx;
      busy            <= busy_nx;
      config_done     <= config_done_nx;
      run_done        <= run_done_nx;
      error           <= error_nx;
    end
  end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Self-checking bench for cgra_config_sequencer using a phase-level timeline model.
module tb_cgra_config_sequencer;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned TIMEOUT       = 8;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start;
  logic        abort;
  logic [31:0] run_cycles;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        cgra_reset_out;
  logic [31:0] config_addr_out;
  logic [31:0] config_data_out;
  logic        busy;
  logic        config_done;
  logic        run_done;
  logic        error;
  logic [31:0] word_count;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  always #5 clk = ~clk;

  cgra_config_sequencer #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT       (TIMEOUT),
    .CNT_W         (32)
  ) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .start           (start),
    .abort           (abort),
    .run_cycles      (run_cycles),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .cfg_last        (cfg_last),
    .cgra_reset_out  (cgra_reset_out),
    .config_addr_out (config_addr_out),
    .config_data_out (config_data_out),
    .busy            (busy),
    .config_done     (config_done),
    .run_done        (run_done),
    .error           (error),
    .word_count      (word_count),
    .cycle_count     (cycle_count)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rst, input logic e_rdy,
                            input logic e_busy, input logic e_cd, input logic e_rd,
                            input logic e_err, input logic [31:0] e_addr,
                            input logic [31:0] e_data, input logic [31:0] e_wc,
                            input logic [31:0] e_cc);
    chk1 ({tag, "_cgra_reset"}, cgra_reset_out, e_rst);
    chk1 ({tag, "_cfg_ready"},  cfg_ready,      e_rdy);
    chk1 ({tag, "_busy"},       busy,           e_busy);
    chk1 ({tag, "_config_done"},config_done,    e_cd);
    chk1 ({tag, "_run_done"},   run_done,       e_rd);
    chk1 ({tag, "_error"},      error,          e_err);
    chk32({tag, "_addr"},       config_addr_out, e_addr);
    chk32({tag, "_data"},       config_data_out, e_data);
    chk32({tag, "_word_count"}, word_count,     e_wc);
    chk32({tag, "_cycle_count"},cycle_count,    e_cc);
  endtask

  function automatic int next_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic load_nominal();
    q_addr.delete(); q_data.delete();
    q_addr.push_back(32'h0001_0001); q_data.push_back(32'h5);
    q_addr.push_back(32'h0002_0001); q_data.push_back(32'h7);
    q_addr.push_back(32'h0003_0001); q_data.push_back(32'h9);
  endtask

  task automatic load_random(input int n);
    q_addr.delete(); q_data.delete();
    for (int i = 0; i < n; i++) begin
      q_addr.push_back($urandom | 32'h0000_0100);
      q_data.push_back($urandom);
    end
  endtask

  // One full sequence from a resting state, checking every cycle against the
  // expected timeline: RST_CYCLES of reset, LOAD until the last word, the word
  // cycle plus SETTLE_CYCLES zero cycles, max(rc,1) RUN cycles, then DONE.
  task automatic do_seq(input logic [31:0] rc, input int gap_mode, input bit stall,
                        input int abort_word, input int reset_run_cycle,
                        input bit start_in_run);
    int nw;
    int idx;
    int gap;
    int nrun;
    bit prev_acc;
    logic [31:0] pa;
    logic [31:0] pd;
    nw   = q_addr.size();
    nrun = (rc == 32'd0) ? 1 : int'(rc);
    @(negedge clk);
    start = 1'b1;
    run_cycles = rc;
    for (int k = 0; k < int'(RST_CYCLES); k++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    end
    idx = 0; prev_acc = 1'b0; pa = '0; pd = '0;
    gap = next_gap(gap_mode);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check_outs("load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 prev_acc ? pa : 32'd0, prev_acc ? pd : 32'd0, 32'(idx), 32'd0);
      if (stall && idx == 1) begin
        cfg_valid = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
          @(negedge clk);
          check_outs("stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          check_outs("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd1, 32'd0);
        end
        return;
      end
      if (idx == abort_word && gap == 0) begin
        cfg_valid = 1'b1; cfg_addr = q_addr[idx]; cfg_data = q_data[idx];
        cfg_last = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; cfg_valid = 1'b0;
        check_outs("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'(idx), 32'd0);
        return;
      end
      if (gap > 0) begin
        cfg_valid = 1'b0; cfg_addr = $urandom; cfg_data = $urandom;
        cfg_last = 1'($urandom_range(0, 1));
        gap--;
        prev_acc = 1'b0;
      end else begin
        cfg_valid = 1'b1; cfg_addr = q_addr[idx]; cfg_data = q_data[idx];
        cfg_last = !stall && (idx == nw - 1);
        pa = q_addr[idx]; pd = q_data[idx];
        prev_acc = 1'b1;
        idx++;
        gap = next_gap(gap_mode);
        if (cfg_last) break;
      end
    end
    for (int s = 0; s <= int'(SETTLE_CYCLES); s++) begin
      @(negedge clk);
      check_outs("settle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                 (s == 0) ? pa : 32'd0, (s == 0) ? pd : 32'd0, 32'(nw), 32'd0);
      cfg_valid = 1'($urandom_range(0, 1)); cfg_addr = $urandom; cfg_data = $urandom;
    end
    for (int j = 0; j < nrun; j++) begin
      @(negedge clk);
      check_outs("run", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'(nw), 32'(j));
      cfg_valid = 1'($urandom_range(0, 1)); cfg_addr = $urandom; cfg_data = $urandom;
      start = start_in_run && (j == 0);
      if (j == reset_run_cycle) begin
        #1 reset_in = 1'b0;
        #1 check_outs("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check_outs("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        reset_in = 1'b1; cfg_valid = 1'b0; start = 1'b0;
        return;
      end
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start = 1'b0; cfg_valid = 1'b0;
      check_outs("done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'(nw), 32'(nrun));
    end
  endtask

  // Directed scenario list with randomized words, gaps and run lengths.
  initial begin
    reset_in = 1'b0; start = 1'b0; abort = 1'b0; run_cycles = '0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("por", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    reset_in = 1'b1;
    @(negedge clk);
    check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    load_nominal();  do_seq(32'd10, 0, 1'b0, -1, -1, 1'b0);
    load_random(4);  do_seq(32'd3, 1, 1'b0, -1, -1, 1'b0);
    load_random(5);  do_seq(32'($urandom_range(1, 20)), 2, 1'b0, -1, -1, 1'b0);
    load_random(1);  do_seq(32'd5, 0, 1'b1, -1, -1, 1'b0);
    load_random(2);  do_seq(32'd2, 2, 1'b0, -1, -1, 1'b0);
    load_random(3);  do_seq(32'd4, 0, 1'b0, 1, -1, 1'b0);
    load_nominal();  do_seq(32'd10, 0, 1'b0, -1, 4, 1'b0);
    load_nominal();  do_seq(32'd10, 0, 1'b0, -1, -1, 1'b0);
    load_random(2);  do_seq(32'd0, 2, 1'b0, -1, -1, 1'b1);
    load_random(6);  do_seq(32'($urandom_range(1, 8)), 2, 1'b0, -1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
Sequences bring-up of the CGRA `top` array: pulses the array reset, streams (addr, data) configuration words into config_addr_in/config_data_in, idles the config bus, then runs the array for a programmed number of cycles. Replaces file-driven configuration in system benches and serves as the on-chip loader behind a host/JTAG-fed word FIFO. Sits between the config-word source (valid/ready) and the array's config and reset pins.

Parameters:
ADDR_W, 32, config address width
DATA_W, 32, config data width
RST_CYCLES, 4, cycles array reset is held asserted (>=1)
SETTLE_CYCLES, 2, cycles of addr=0 after the last word before RUN (>=0)
TIMEOUT, 1024, max consecutive LOAD cycles with cfg_valid low before ERROR
CNT_W, 32, width of run/word counters

Ports:
clk_in  in  1  system clock
reset_in  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin sequence (honoured in IDLE, DONE, ERROR only)
abort  in  1  return to IDLE from any state next cycle
run_cycles  in  CNT_W  cycles to run after configuration; sampled on start
cfg_valid  in  1  config word available
cfg_ready  out  1  sequencer accepts word this cycle
cfg_addr  in  ADDR_W  word address
cfg_data  in  DATA_W  word data
cfg_last  in  1  marks final word of the bitstream
cgra_reset_out  out  1  active-high reset to array (reset_in pin of top)
config_addr_out  out  ADDR_W  to config_addr_in
config_data_out  out  DATA_W  to config_data_in
busy  out  1  state not IDLE/DONE/ERROR
config_done  out  1  high from entry to RUN until next start/abort/reset
run_done  out  1  high in DONE
error  out  1  high in ERROR
word_count  out  CNT_W  words accepted this sequence
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset values: state IDLE; cfg_ready 0; cgra_reset_out 1 (array held in reset); config_addr_out/config_data_out 0; busy/config_done/run_done/error 0; counters 0.
- States: IDLE, RST, LOAD, SETTLE, RUN, DONE, ERROR. All outputs are registered.
- IDLE: cgra_reset_out 1. start -> RST; clears word_count, cycle_count; latches run_cycles.
- RST: cgra_reset_out 1 for exactly RST_CYCLES cycles, then deasserts on LOAD entry.
- LOAD: cfg_ready=1. Handshake on cfg_valid&cfg_ready. Accepted word appears on config_addr_out/config_data_out the next cycle for exactly one cycle; otherwise the bus is addr=0, data=0 (0 = no-op address). word_count increments per accepted word. Accepting with cfg_last -> SETTLE (or RUN if SETTLE_CYCLES=0); cfg_ready drops the cycle after last. Idle counter resets on every accept; reaching TIMEOUT consecutive idle cycles -> ERROR. Back-to-back words are accepted every cycle (throughput 1 word/cycle).
- SETTLE: bus 0 for SETTLE_CYCLES, then RUN.
- RUN: config_done=1; cycle_count increments each cycle; when cycle_count==run_cycles-1 transition to DONE (exactly run_cycles RUN cycles). run_cycles=0 -> DONE after one RUN cycle (treated as 1).
- DONE: run_done=1, config_done stays 1, cycle_count holds. start -> RST.
- ERROR: error=1, cgra_reset_out=1, bus 0; start -> RST.
- abort (highest priority, including over start and handshake): next state IDLE, cgra_reset_out 1, bus 0, cfg_ready 0; a word presented that cycle is NOT accepted.
- start outside IDLE/DONE/ERROR ignored.
- Counters saturate at all-ones, no wrap.
- Async reset mid-LOAD: immediate return to reset values; partially loaded words are discarded; no bus glitch beyond reset values.

Decomposition:
- Package cgra_cfg_pkg: state enum, ADDR_W/DATA_W defaults, CFG_NOP_ADDR=0.
- One sub-module: cgra_cfg_sat_counter (parameterised width, clear/inc/saturate), instantiated for word, cycle, phase and idle counters.

Test Plan:
- Nominal: start, run_cycles=10, 3 words (0x00010001/0x5,0x00020001/0x7,0x00030001/0x9 last) back-to-back -> cgra_reset_out high 4 cycles, three consecutive bus cycles with those values, 2 zero cycles, config_done, DONE after exactly 10 RUN cycles, word_count=3, cycle_count=10.
- Gapped stream: valid toggling 1/0 -> each word driven exactly once, one cycle, zeros between; no duplicates.
- Timeout: TIMEOUT=8, one word then valid low -> error=1 after 8 idle cycles, cgra_reset_out=1; subsequent start restarts cleanly with counters 0.
- Abort mid-LOAD with cfg_valid high -> word not accepted, IDLE next cycle, bus 0, cfg_ready 0.
- Async reset asserted mid-RUN -> all outputs at reset values immediately; start after release repeats nominal sequence.
- run_cycles=0 and start during RUN -> DONE after 1 RUN cycle; mid-run start ignored.
